// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

  // SPI mode as driven on the mode pins: {CPOL, CPHA}
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Frame state: idle between cs_n frames, transferring inside one
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t XFER = 1'b1;

  // CPHA value for which the receive sample happens on the leading edge
  localparam logic SAMPLE_LEADING_CPHA = 1'b0;

  function automatic logic sample_on_leading(input logic cpha);
    return cpha == SAMPLE_LEADING_CPHA;
  endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI bus pins between a master and this responder.
interface spi_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    output miso,
    output miso_oe
  );

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    input  miso,
    input  miso_oe
  );
endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous input, with single-cycle
// rise and fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Shift the pin through the flop chain and keep a delayed copy for edges
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples the bus in the clk domain, receives MSB-first
// words on mosi and returns words from a one-deep holding buffer on miso.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_if.slave       bus,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun
);
  import spi_pkg::*;

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(bus.sclk),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n idles high, so its chain resets high to avoid a false frame start
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(bus.cs_n),
    .q(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(bus.mosi),
    .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t           state;
  spi_mode_t        mode_q;
  spi_mode_t        start_mode;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] next_word;
  logic             first_word;
  logic             miso_q;
  logic             oe_q;

  logic in_xfer, start, abort;
  logic leading, trailing, sample_lead;
  logic sample_edge, shift_edge, reload, word_load;

  assign start_mode  = spi_mode_t'(mode);
  assign in_xfer     = (state == XFER);
  assign start       = (state == IDLE) && cs_fall;
  assign abort       = in_xfer && cs_rise;

  assign leading     = mode_q.cpol ? sclk_fall : sclk_rise;
  assign trailing    = mode_q.cpol ? sclk_rise : sclk_fall;
  assign sample_lead = sample_on_leading(mode_q.cpha);

  // A frame end takes priority over any sclk edge seen in the same cycle
  assign sample_edge = in_xfer && !cs_rise && (sample_lead ? leading : trailing);
  assign shift_edge  = in_xfer && !cs_rise && (sample_lead ? trailing : leading);

  // The first shift point of every word after the first one loads a new word;
  // for CPHA=1 the very first leading edge only presents the preloaded MSB
  assign reload    = shift_edge && (bit_cnt == '0) && !first_word;
  assign word_load = start || reload;
  assign next_word = tx_ready ? '0 : hold;

  assign bus.miso    = miso_q;
  assign bus.miso_oe = oe_q;

  // Frame state machine and transmit shifter driving miso
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= '0;
      tx_shift   <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      first_word <= 1'b0;
    end else if (start) begin
      state      <= XFER;
      mode_q     <= start_mode;
      oe_q       <= 1'b1;
      first_word <= start_mode.cpha;
      if (sample_on_leading(start_mode.cpha)) begin
        miso_q   <= next_word[WIDTH-1];
        tx_shift <= {next_word[WIDTH-2:0], 1'b0};
      end else begin
        tx_shift <= next_word;
      end
    end else if (abort) begin
      state      <= IDLE;
      oe_q       <= 1'b0;
      miso_q     <= 1'b0;
      tx_shift   <= '0;
      first_word <= 1'b0;
    end else if (reload) begin
      miso_q   <= next_word[WIDTH-1];
      tx_shift <= {next_word[WIDTH-2:0], 1'b0};
    end else if (shift_edge) begin
      miso_q     <= tx_shift[WIDTH-1];
      tx_shift   <= {tx_shift[WIDTH-2:0], 1'b0};
      first_word <= 1'b0;
    end
  end

  // Receive shifter, bit counter and completed-word output
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (start || abort) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= {rx_shift[WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Holding buffer: a word load empties it first, so a coincident tx_load refills it
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= word_load && tx_ready;
      if (tx_load && (tx_ready || word_load)) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (word_load) begin
        tx_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave with a behavioural SPI master.
module tb_spi_slave;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int H     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;

  spi_slave_if bus ();

  spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .mode(mode),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rx_pulses = 0;
  int ur_pulses = 0;
  int stab_errs = 0;

  // Free-running pulse counters; tests look at the difference across a frame
  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (tx_underrun) ur_pulses++;
  end

  typedef struct {
    logic [1:0] mode;
    logic       preload;
    logic [7:0] tx_word;
    logic [7:0] mosi_word;
    logic [7:0] exp_master;
    logic [7:0] exp_rx;
    int         exp_underruns;
  } vec_t;

  vec_t vecs[7];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic frame_begin(input logic [1:0] m);
    mode     = m;
    bus.sclk = m[1];
    wait_clk(4);
    bus.cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end();
    wait_clk(H);
    bus.cs_n = 1'b1;
    wait_clk(2 * H);
  endtask

  // Master side of nbits bit-times; miso must hold from the sample edge
  // until the following shift edge
  task automatic xfer_bits(input logic [1:0] m, input int nbits, input logic [7:0] out,
                           output logic [7:0] got, input int load_at, input logic [7:0] load_val);
    logic cpol, cpha, v1;
    cpol = m[1];
    cpha = m[0];
    got  = '0;
    for (int k = 0; k < nbits; k++) begin
      if (k == load_at) pulse_load(load_val);
      if (!cpha) begin
        bus.mosi = out[7-k];
        wait_clk(H);
        got[7-k] = bus.miso;
        v1 = bus.miso;
        bus.sclk = ~cpol;
        wait_clk(H);
        if (bus.miso !== v1) stab_errs++;
        bus.sclk = cpol;
      end else begin
        bus.sclk = ~cpol;
        bus.mosi = out[7-k];
        wait_clk(H);
        got[7-k] = bus.miso;
        bus.sclk = cpol;
        wait_clk(H);
        if (bus.miso !== got[7-k]) stab_errs++;
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [7:0] got;
    int r0, u0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.preload) begin
      pulse_load(v.tx_word);
      check_output({tag, "_ready_after_load"}, tx_ready, 1'b0);
    end
    r0 = rx_pulses;
    u0 = ur_pulses;
    stab_errs = 0;
    frame_begin(v.mode);
    check_output({tag, "_oe_active"}, bus.miso_oe, 1'b1);
    xfer_bits(v.mode, 8, v.mosi_word, got, -1, 8'h00);
    frame_end();
    check_output({tag, "_master_rx"}, got, v.exp_master);
    check_output({tag, "_rx_data"}, rx_data, v.exp_rx);
    check_output({tag, "_rx_valid_count"}, rx_pulses - r0, 1);
    check_output({tag, "_underrun_count"}, ur_pulses - u0, v.exp_underruns);
    check_output({tag, "_miso_stable"}, stab_errs, 0);
    check_output({tag, "_oe_idle"}, bus.miso_oe, 1'b0);
    check_output({tag, "_miso_idle"}, bus.miso, 1'b0);
    check_output({tag, "_ready_idle"}, tx_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] g0, g1;
    int r0, u0;

    // CPHA=0 rows see one extra load at the final trailing edge, which
    // underruns because nothing was reloaded during the word
    vecs[0] = '{2'b00, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
    vecs[1] = '{2'b01, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[2] = '{2'b10, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
    vecs[3] = '{2'b11, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0};
    vecs[4] = '{2'b00, 1'b0, 8'h00, 8'hC3, 8'h00, 8'hC3, 2};
    vecs[5] = '{2'b11, 1'b0, 8'h00, 8'h96, 8'h00, 8'h96, 1};
    vecs[6] = '{2'b01, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 0};

    rst      = 1'b1;
    mode     = 2'b00;
    tx_data  = '0;
    tx_load  = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clk(3);
    check_output("reset_tx_ready", tx_ready, 1'b1);
    check_output("reset_rx_valid", rx_valid, 1'b0);
    check_output("reset_rx_data", rx_data, 8'h00);
    check_output("reset_underrun", tx_underrun, 1'b0);
    check_output("reset_miso", bus.miso, 1'b0);
    check_output("reset_miso_oe", bus.miso_oe, 1'b0);
    rst = 1'b0;
    wait_clk(3);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], i);

    // Two words in one frame, refilling the buffer during each word;
    // a mode change mid-frame must be ignored
    pulse_load(8'hA5);
    r0 = rx_pulses;
    u0 = ur_pulses;
    stab_errs = 0;
    frame_begin(2'b00);
    mode = 2'b11;
    xfer_bits(2'b00, 8, 8'h11, g0, 2, 8'h5A);
    check_output("b2b_rx_word1", rx_data, 8'h11);
    xfer_bits(2'b00, 8, 8'h22, g1, 2, 8'hFF);
    frame_end();
    mode = 2'b00;
    check_output("b2b_master_word1", g0, 8'hA5);
    check_output("b2b_master_word2", g1, 8'h5A);
    check_output("b2b_rx_word2", rx_data, 8'h22);
    check_output("b2b_rx_valid_count", rx_pulses - r0, 2);
    check_output("b2b_underrun_count", ur_pulses - u0, 0);
    check_output("b2b_miso_stable", stab_errs, 0);

    // Abort after 5 bits; a word loaded during the aborted frame survives
    r0 = rx_pulses;
    frame_begin(2'b00);
    xfer_bits(2'b00, 5, 8'hFF, g0, 1, 8'hC3);
    frame_end();
    check_output("abort_rx_valid_count", rx_pulses - r0, 0);
    check_output("abort_rx_data_kept", rx_data, 8'h22);
    check_output("abort_miso_oe", bus.miso_oe, 1'b0);
    check_output("abort_miso", bus.miso, 1'b0);
    check_output("abort_buffer_kept", tx_ready, 1'b0);
    r0 = rx_pulses;
    frame_begin(2'b00);
    xfer_bits(2'b00, 8, 8'h69, g0, -1, 8'h00);
    frame_end();
    check_output("post_abort_rx", rx_data, 8'h69);
    check_output("post_abort_rx_valid_count", rx_pulses - r0, 1);
    check_output("post_abort_master_rx", g0, 8'hC3);

    // A load while the buffer is full is dropped
    pulse_load(8'h4D);
    pulse_load(8'hB2);
    check_output("full_load_ready", tx_ready, 1'b0);
    frame_begin(2'b01);
    xfer_bits(2'b01, 8, 8'h0F, g0, -1, 8'h00);
    frame_end();
    check_output("full_load_master_rx", g0, 8'h4D);
    check_output("full_load_rx", rx_data, 8'h0F);

    // Reset in the middle of a word with the buffer full
    frame_begin(2'b00);
    xfer_bits(2'b00, 3, 8'hAA, g0, 1, 8'h99);
    check_output("pre_rst_ready", tx_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_output("midrst_tx_ready", tx_ready, 1'b1);
    check_output("midrst_rx_valid", rx_valid, 1'b0);
    check_output("midrst_rx_data", rx_data, 8'h00);
    check_output("midrst_underrun", tx_underrun, 1'b0);
    check_output("midrst_miso", bus.miso, 1'b0);
    check_output("midrst_miso_oe", bus.miso_oe, 1'b0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    u0 = ur_pulses;
    frame_begin(2'b01);
    xfer_bits(2'b01, 8, 8'h5C, g0, -1, 8'h00);
    frame_end();
    check_output("post_rst_master_rx", g0, 8'h00);
    check_output("post_rst_rx", rx_data, 8'h5C);
    check_output("post_rst_underrun_count", ur_pulses - u0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
